// File: rtl/sniff_match_controller.sv
// Sequences sniffer frames: SOP capture, post-EOP drain, weighted match decision, log strobe.
// Outputs registered from next_state; ready withheld outside CAPTURE/ERROR/IDLE (IDLE also needs empty<3).
module sniff_match_controller #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 64,
  parameter int WEIGHT_W = 4,
  parameter int WAIT_CYC = 4,
  localparam int SCORE_W = WEIGHT_W + $clog2(NCH)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    update_done,
  input  logic                    sop,
  input  logic                    eop,
  input  logic                    valid,
  input  logic [5:0]              error,
  input  logic [1:0]              empty,
  input  logic [NCH-1:0]          match,
  input  logic [NCH*WEIGHT_W-1:0] weights,
  input  logic [SCORE_W-1:0]      threshold,
  input  logic                    hit_clr,
  output logic                    ready,
  output logic                    inc_addr,
  output logic                    clear,
  output logic [NCH*CNT_W-1:0]    hits,
  output logic [CNT_W-1:0]        pkt_count,
  output logic [CNT_W-1:0]        err_count
);

  localparam int DW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  typedef enum logic [2:0] {
    INIT, LOAD_CFG, IDLE, CAPTURE, DRAIN, DECIDE, LOG, ERROR
  } state_t;

  state_t                       state, next_state;
  logic [DW-1:0]                drain_cnt;
  logic [SCORE_W-1:0]           score;
  logic                         err_inc;
  logic [NCH-1:0][CNT_W-1:0]    hit_q;

  assign hits = hit_q;

  always_comb begin
    score = '0;
    for (int i = 0; i < NCH; i++) begin
      if (match[i]) score = score + SCORE_W'(weights[i*WEIGHT_W +: WEIGHT_W]);
    end
  end

  always_comb begin
    next_state = state;
    err_inc    = 1'b0;
    case (state)
      INIT:     next_state = LOAD_CFG;
      LOAD_CFG: if (update_done) next_state = IDLE;
      IDLE:     if (sop && valid) next_state = CAPTURE;
      CAPTURE: begin
        if (valid && (error != 6'd0)) begin
          err_inc    = 1'b1;
          next_state = eop ? IDLE : ERROR;
        end else if (valid && eop) begin
          next_state = (WAIT_CYC == 0) ? DECIDE : DRAIN;
        end else if (valid && sop) begin
          // restarted frame: the aborted one counts as an error
          err_inc = 1'b1;
        end
      end
      DRAIN:    if (drain_cnt == '0) next_state = DECIDE;
      DECIDE:   next_state = (score >= threshold) ? LOG : IDLE;
      LOG:      next_state = IDLE;
      ERROR:    if (valid && eop) next_state = IDLE;
      default:  next_state = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= INIT;
      drain_cnt <= '0;
      ready     <= 1'b0;
      clear     <= 1'b0;
      inc_addr  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == CAPTURE) drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
      ready    <= (next_state == CAPTURE) || (next_state == ERROR) ||
                  ((next_state == IDLE) && (empty < 2'd3));
      clear    <= (next_state == IDLE) || (next_state == DECIDE);
      inc_addr <= (next_state == LOG);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hit_q     <= '0;
      pkt_count <= '0;
      err_count <= '0;
    end else if (hit_clr) begin
      hit_q     <= '0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (state == DECIDE) begin
        for (int i = 0; i < NCH; i++) begin
          if (match[i] && !(&hit_q[i])) hit_q[i] <= hit_q[i] + 1'b1;
        end
        if (!(&pkt_count)) pkt_count <= pkt_count + 1'b1;
      end
      if (err_inc && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sniff_match_controller.sv
// Drives two controllers (drain 4 / 4-bit counters, drain 0 / 8-bit counters) from shared stimulus.
module tb_sniff_match_controller;

  localparam int W_A = 4;
  localparam int W_B = 0;
  localparam int MAX_A = 15;
  localparam int MAX_B = 255;

  logic        clk = 1'b0;
  logic        n_rst, update_done, sop, eop, valid, hit_clr;
  logic [5:0]  error;
  logic [1:0]  empty;
  logic [3:0]  match;
  logic [15:0] weights;
  logic [5:0]  threshold;

  logic        ready_a, inc_a, clear_a, ready_b, inc_b, clear_b;
  logic [15:0] hits_a;
  logic [3:0]  pkt_a, err_a;
  logic [31:0] hits_b;
  logic [7:0]  pkt_b, err_b;

  int checks = 0;
  int failures = 0;
  int exp_hits_a[4], exp_hits_b[4];
  int exp_pkt_a, exp_pkt_b, exp_err_a, exp_err_b;

  always #5 clk = ~clk;

  sniff_match_controller #(.NCH(4), .CNT_W(4), .WEIGHT_W(4), .WAIT_CYC(W_A)) u_dut_a (
    .clk(clk), .n_rst(n_rst), .update_done(update_done), .sop(sop), .eop(eop),
    .valid(valid), .error(error), .empty(empty), .match(match), .weights(weights),
    .threshold(threshold), .hit_clr(hit_clr), .ready(ready_a), .inc_addr(inc_a),
    .clear(clear_a), .hits(hits_a), .pkt_count(pkt_a), .err_count(err_a));

  sniff_match_controller #(.NCH(4), .CNT_W(8), .WEIGHT_W(4), .WAIT_CYC(W_B)) u_dut_b (
    .clk(clk), .n_rst(n_rst), .update_done(update_done), .sop(sop), .eop(eop),
    .valid(valid), .error(error), .empty(empty), .match(match), .weights(weights),
    .threshold(threshold), .hit_clr(hit_clr), .ready(ready_b), .inc_addr(inc_b),
    .clear(clear_b), .hits(hits_b), .pkt_count(pkt_b), .err_count(err_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 4; i++) begin
      exp_hits_a[i] = 0;
      exp_hits_b[i] = 0;
    end
    exp_pkt_a = 0; exp_pkt_b = 0; exp_err_a = 0; exp_err_b = 0;
  endtask

  task automatic model_err();
    exp_err_a = sat_inc(exp_err_a, MAX_A);
    exp_err_b = sat_inc(exp_err_b, MAX_B);
  endtask

  task automatic check_counters(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_hits_a"}, 64'(hits_a[i*4 +: 4]), 64'(exp_hits_a[i]));
      chk({tag, "_hits_b"}, 64'(hits_b[i*8 +: 8]), 64'(exp_hits_b[i]));
    end
    chk({tag, "_pkt_a"}, 64'(pkt_a), 64'(exp_pkt_a));
    chk({tag, "_pkt_b"}, 64'(pkt_b), 64'(exp_pkt_b));
    chk({tag, "_err_a"}, 64'(err_a), 64'(exp_err_a));
    chk({tag, "_err_b"}, 64'(err_b), 64'(exp_err_b));
  endtask

  // One good frame; n counts edges after the EOP edge, sampled just after each edge.
  task automatic run_pkt(input logic [3:0] m, input bit extra_sop, input bit hclr, input string tag);
    int  score;
    bit  logged;
    int  first_inc_a, first_inc_b, n_inc_a, n_inc_b, first_rdy_a, first_rdy_b;
    logic clr_dec_a, clr_dec_b;
    match = m;
    score = 0;
    for (int i = 0; i < 4; i++) if (m[i]) score += int'(weights[i*4 +: 4]);
    logged = (score >= int'(threshold));

    sop = 1'b1; valid = 1'b1;
    tick();
    sop = 1'b0; valid = 1'b0;
    chk({tag, "_cap_ready_a"}, 64'(ready_a), 64'(1));
    chk({tag, "_cap_clear_a"}, 64'(clear_a), 64'(0));
    chk({tag, "_cap_clear_b"}, 64'(clear_b), 64'(0));
    tick();
    if (extra_sop) begin
      sop = 1'b1; valid = 1'b1;
      tick();
      sop = 1'b0; valid = 1'b0;
      model_err();
      chk({tag, "_restart_ready_b"}, 64'(ready_b), 64'(1));
      chk({tag, "_restart_clear_b"}, 64'(clear_b), 64'(0));
    end
    tick();
    eop = 1'b1; valid = 1'b1;
    tick();
    eop = 1'b0; valid = 1'b0;

    first_inc_a = -1; first_inc_b = -1; n_inc_a = 0; n_inc_b = 0;
    first_rdy_a = -1; first_rdy_b = -1; clr_dec_a = 1'b0; clr_dec_b = 1'b0;
    for (int n = 0; n <= 8; n++) begin
      if (inc_a) begin if (first_inc_a < 0) first_inc_a = n; n_inc_a++; end
      if (inc_b) begin if (first_inc_b < 0) first_inc_b = n; n_inc_b++; end
      if (ready_a && first_rdy_a < 0) first_rdy_a = n;
      if (ready_b && first_rdy_b < 0) first_rdy_b = n;
      if (n == W_A) clr_dec_a = clear_a;
      if (n == W_B) clr_dec_b = clear_b;
      hit_clr = hclr && (n == W_A);
      tick();
    end
    hit_clr = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        exp_hits_a[i] = sat_inc(exp_hits_a[i], MAX_A);
        exp_hits_b[i] = sat_inc(exp_hits_b[i], MAX_B);
      end
    end
    exp_pkt_a = sat_inc(exp_pkt_a, MAX_A);
    exp_pkt_b = sat_inc(exp_pkt_b, MAX_B);
    if (hclr) model_zero();

    chk({tag, "_inc_at_a"}, 64'(first_inc_a), logged ? 64'(W_A + 1) : 64'(-1));
    chk({tag, "_inc_at_b"}, 64'(first_inc_b), logged ? 64'(W_B + 1) : 64'(-1));
    chk({tag, "_inc_len_a"}, 64'(n_inc_a), 64'(logged));
    chk({tag, "_inc_len_b"}, 64'(n_inc_b), 64'(logged));
    chk({tag, "_idle_at_a"}, 64'(first_rdy_a), 64'(logged ? W_A + 2 : W_A + 1));
    chk({tag, "_idle_at_b"}, 64'(first_rdy_b), 64'(logged ? W_B + 2 : W_B + 1));
    chk({tag, "_clr_decide_a"}, 64'(clr_dec_a), 64'(1));
    chk({tag, "_clr_decide_b"}, 64'(clr_dec_b), 64'(1));
    check_counters(tag);
  endtask

  task automatic err_pkt(input bit with_eop, input string tag);
    sop = 1'b1; valid = 1'b1;
    tick();
    sop = 1'b0; valid = 1'b0;
    tick();
    error = 6'($urandom_range(1, 63)); valid = 1'b1; eop = with_eop;
    tick();
    error = 6'd0; valid = 1'b0; eop = 1'b0;
    model_err();
    chk({tag, "_ready_a"}, 64'(ready_a), 64'(1));
    chk({tag, "_clear_a"}, 64'(clear_a), 64'(with_eop));
    chk({tag, "_clear_b"}, 64'(clear_b), 64'(with_eop));
    if (!with_eop) begin
      // SOP and a second error inside ERROR must be ignored
      sop = 1'b1; valid = 1'b1; error = 6'h3f;
      tick();
      sop = 1'b0; valid = 1'b0; error = 6'd0;
      tick();
      chk({tag, "_hold_ready_b"}, 64'(ready_b), 64'(1));
      eop = 1'b1; valid = 1'b1;
      tick();
      eop = 1'b0; valid = 1'b0;
      chk({tag, "_exit_clear_a"}, 64'(clear_a), 64'(1));
      chk({tag, "_exit_clear_b"}, 64'(clear_b), 64'(1));
    end
    repeat (3) tick();
    check_counters(tag);
  endtask

  initial begin
    n_rst = 1'b0; update_done = 1'b0; sop = 1'b0; eop = 1'b0; valid = 1'b0;
    hit_clr = 1'b0; error = 6'd0; empty = 2'd0; match = 4'd0;
    weights = {4'd4, 4'd2, 4'd2, 4'd1}; threshold = 6'd4;
    model_zero();
    repeat (3) tick();
    chk("rst_ready_a", 64'(ready_a), 64'(0));
    chk("rst_inc_a", 64'(inc_a), 64'(0));
    chk("rst_clear_b", 64'(clear_b), 64'(0));
    check_counters("rst");

    n_rst = 1'b1;
    tick();
    chk("init_ready_a", 64'(ready_a), 64'(0));
    tick();
    chk("cfg_ready_a", 64'(ready_a), 64'(0));
    chk("cfg_clear_a", 64'(clear_a), 64'(0));
    update_done = 1'b1;
    tick();
    update_done = 1'b0;
    chk("idle_ready_a", 64'(ready_a), 64'(1));
    chk("idle_ready_b", 64'(ready_b), 64'(1));
    chk("idle_clear_a", 64'(clear_a), 64'(1));
    empty = 2'd3;
    tick();
    chk("empty3_ready_a", 64'(ready_a), 64'(0));
    chk("empty3_ready_b", 64'(ready_b), 64'(0));
    empty = 2'd2;
    tick();
    chk("empty2_ready_a", 64'(ready_a), 64'(1));
    empty = 2'd0;
    tick();

    run_pkt(4'b0110, 1'b0, 1'b0, "log_0110");
    run_pkt(4'b0001, 1'b0, 1'b0, "nolog_0001");
    err_pkt(1'b0, "err_noeop");
    err_pkt(1'b1, "err_eop");

    threshold = 6'd0;
    for (int k = 0; k < 16; k++) run_pkt(4'b0001, 1'b0, 1'b0, "sat");
    chk("sat_hits0_a", 64'(hits_a[3:0]), 64'(15));
    run_pkt(4'b0011, 1'b0, 1'b1, "hitclr");
    chk("hitclr_pkt_a", 64'(pkt_a), 64'(0));

    weights = {4'd4, 4'd2, 4'd2, 4'd1}; threshold = 6'd4;
    run_pkt(4'b1000, 1'b1, 1'b0, "restart");

    for (int k = 0; k < 20; k++) begin
      weights   = 16'($urandom);
      threshold = 6'($urandom_range(0, 40));
      run_pkt(4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), "rand");
      if ($urandom_range(0, 4) == 0) err_pkt(1'($urandom_range(0, 1)), "rand_err");
    end

    // asynchronous reset in the middle of a frame
    sop = 1'b1; valid = 1'b1;
    tick();
    sop = 1'b0; valid = 1'b0;
    tick();
    #2 n_rst = 1'b0;
    #1;
    model_zero();
    chk("arst_ready_a", 64'(ready_a), 64'(0));
    chk("arst_clear_b", 64'(clear_b), 64'(0));
    check_counters("arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
